imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the RV32/RV64 datapath.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Decodes the format (R/I/S/B/U/J) and produces a fully sign-extended XLEN-bit immediate two cycles later, with a format code and an unknown-opcode flag.
- Keeps a saturating count of unknown opcodes. Sits between instruction register and ALU-B mux / branch adder.

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 136 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction register, the immediate generator and its consumer.
// The master modport is the producer/consumer side; the slave modport is the generator side.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_err, err_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined RV32/RV64 immediate generator with a saturating unknown-opcode counter.
// Optional macro IMM_SHAMT_EN: shift-immediate instructions return the zero-extended shamt.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;
    localparam bit         IS64    = (XLEN == 64);

    logic             r_run;
    logic             r_s1_valid;
    logic [31:0]      r_s1_instr;
    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_imm;
    logic [2:0]       r_s2_fmt;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic             w_sign;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_err;
    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_s12_fire;

    assign w_opcode = r_s1_instr[6:0];
    assign w_funct3 = r_s1_instr[14:12];
    assign w_sign   = r_s1_instr[31];

    always_comb begin
        w_fmt   = FMT_R;
        w_imm32 = 32'd0;
        case (w_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: w_fmt = FMT_I;
            7'b0011011:                         w_fmt = IS64 ? FMT_I : FMT_UNK;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            7'b0110011, 7'b0001111, 7'b1110011: w_fmt = FMT_R;
            7'b0111011:                         w_fmt = IS64 ? FMT_R : FMT_UNK;
            default:                            w_fmt = FMT_UNK;
        endcase

        case (w_fmt)
            FMT_I:   w_imm32 = {{20{w_sign}}, r_s1_instr[31:20]};
            FMT_S:   w_imm32 = {{20{w_sign}}, r_s1_instr[31:25], r_s1_instr[11:7]};
            FMT_B:   w_imm32 = {{19{w_sign}}, r_s1_instr[31], r_s1_instr[7],
                                r_s1_instr[30:25], r_s1_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {r_s1_instr[31:12], 12'd0};
            FMT_J:   w_imm32 = {{11{w_sign}}, r_s1_instr[31], r_s1_instr[19:12],
                                r_s1_instr[20], r_s1_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase

`ifdef IMM_SHAMT_EN
        // Shift-immediates: bit 30 only selects arithmetic vs logical, so keep just the shamt.
        if ((w_opcode == 7'b0010011 || (w_opcode == 7'b0011011 && IS64)) &&
            (w_funct3 == 3'b001 || w_funct3 == 3'b101)) begin
            if (IS64) begin
                w_imm32 = {26'd0, r_s1_instr[25:20]};
            end else begin
                w_imm32 = {27'd0, r_s1_instr[24:20]};
            end
        end
`endif
    end

    assign w_err = (w_fmt == FMT_UNK);

    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi = gi + 1) begin : g_sext
            assign w_imm[gi] = w_imm32[31];
        end
    endgenerate
    assign w_imm[31:0] = w_imm32;

    // r_run keeps in_ready low until the first edge after reset release.
    assign w_s2_ready = !r_s2_valid || bus.out_ready;
    assign w_s1_ready = r_run && (!r_s1_valid || w_s2_ready);
    assign w_s12_fire = r_s1_valid && w_s2_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_instr <= 32'd0;
            r_s2_valid <= 1'b0;
            r_s2_imm   <= '0;
            r_s2_fmt   <= FMT_R;
            r_s2_err   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_s1_ready) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_instr <= bus.in_instr;
                end
            end
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_imm <= w_imm;
                    r_s2_fmt <= w_fmt;
                    r_s2_err <= w_err;
                end
            end
            if (w_s12_fire && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_s1_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_imm   = r_s2_imm;
    assign bus.out_fmt   = r_s2_fmt;
    assign bus.out_err   = r_s2_err;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV64 instance (2-bit counter) and an RV32 instance share one stimulus
// stream; a vector table feeds per-instance scoreboard queues checked by a negedge monitor.
module tb_imm_gen_pipe;
    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
    } vec_t;

`ifdef IMM_SHAMT_EN
    localparam logic [63:0] SRAI_IMM = 64'h3;
`else
    localparam logic [63:0] SRAI_IMM = 64'h403;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tb_valid = 1'b0;
    logic [31:0] tb_instr = 32'd0;
    logic        tb_oready = 1'b1;
    bit          rand_rdy = 1'b0;

    int checks = 0;
    int errors = 0;
    int nerr64 = 0;
    int nerr32 = 0;
    vec_t q64[$];
    vec_t q32[$];
    vec_t vecs[17];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .CNT_W(2)) if64 ();
    imm_gen_pipe_if #(.XLEN(32), .CNT_W(8)) if32 ();

    assign if64.in_valid  = tb_valid;
    assign if64.in_instr  = tb_instr;
    assign if64.out_ready = tb_oready;
    assign if32.in_valid  = tb_valid;
    assign if32.in_instr  = tb_instr;
    assign if32.out_ready = tb_oready;

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64));
    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] imm64,
                                input logic [2:0] fmt64, input logic [31:0] imm32,
                                input logic [2:0] fmt32);
        vec_t v;
        v.instr = instr; v.imm64 = imm64; v.fmt64 = fmt64; v.imm32 = imm32; v.fmt32 = fmt32;
        return v;
    endfunction

    // Offer one instruction; expected results are queued on the cycle it is accepted.
    task automatic send(input vec_t v);
        bit done = 1'b0;
        tb_valid = 1'b1;
        tb_instr = v.instr;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (if64.in_ready === 1'b1) begin
                q64.push_back(v);
                q32.push_back(v);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr 0x%08h not accepted, in_ready=%b required 1", v.instr, if64.in_ready);
        end
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q64.size() != 0 || q32.size() != 0); k++) @(posedge clk);
        #1;
        chk("drain_q64_left", 64'(q64.size()), 64'd0);
        chk("drain_q32_left", 64'(q32.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        q64.delete(); q32.delete();
        nerr64 = 0; nerr32 = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) tb_oready = 1'($urandom_range(0, 1));
    end

    // Output monitor: pops the scoreboard on every output transfer, checks hold under stall.
    initial begin
        bit hold64 = 1'b0;
        bit hold32 = 1'b0;
        logic [63:0] h64_imm;
        logic [2:0]  h64_fmt;
        logic [31:0] h32_imm;
        logic [2:0]  h32_fmt;
        vec_t e;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                hold64 = 1'b0;
                hold32 = 1'b0;
                continue;
            end
            if (if64.out_valid === 1'b1) begin
                if (hold64) begin
                    chk("hold_imm64", if64.out_imm, h64_imm);
                    chk("hold_fmt64", 64'(if64.out_fmt), 64'(h64_fmt));
                end
                if (tb_oready) begin
                    hold64 = 1'b0;
                    if (q64.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out64: imm=0x%0h fmt=%0d, required no output", if64.out_imm, if64.out_fmt);
                    end else begin
                        e = q64.pop_front();
                        if (e.fmt64 == 3'd7) nerr64++;
                        $display("xlen64 instr=%08h imm=%016h fmt=%0d err=%b cnt=%0d",
                                 e.instr, if64.out_imm, if64.out_fmt, if64.out_err, if64.err_cnt);
                        chk("imm64", if64.out_imm, e.imm64);
                        chk("fmt64", 64'(if64.out_fmt), 64'(e.fmt64));
                        chk("err64", 64'(if64.out_err), 64'(e.fmt64 == 3'd7));
                        chk("cnt64", 64'(if64.err_cnt), 64'((nerr64 > 3) ? 3 : nerr64));
                    end
                end else begin
                    hold64 = 1'b1;
                    h64_imm = if64.out_imm;
                    h64_fmt = if64.out_fmt;
                end
            end else begin
                if (hold64) chk("stall_valid64", 64'(if64.out_valid), 64'd1);
                hold64 = 1'b0;
            end

            if (if32.out_valid === 1'b1) begin
                if (hold32) begin
                    chk("hold_imm32", 64'(if32.out_imm), 64'(h32_imm));
                    chk("hold_fmt32", 64'(if32.out_fmt), 64'(h32_fmt));
                end
                if (tb_oready) begin
                    hold32 = 1'b0;
                    if (q32.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out32: imm=0x%0h fmt=%0d, required no output", if32.out_imm, if32.out_fmt);
                    end else begin
                        e = q32.pop_front();
                        if (e.fmt32 == 3'd7) nerr32++;
                        $display("xlen32 instr=%08h imm=%08h fmt=%0d err=%b cnt=%0d",
                                 e.instr, if32.out_imm, if32.out_fmt, if32.out_err, if32.err_cnt);
                        chk("imm32", 64'(if32.out_imm), 64'(e.imm32));
                        chk("fmt32", 64'(if32.out_fmt), 64'(e.fmt32));
                        chk("err32", 64'(if32.out_err), 64'(e.fmt32 == 3'd7));
                        chk("cnt32", 64'(if32.err_cnt), 64'((nerr32 > 255) ? 255 : nerr32));
                    end
                end else begin
                    hold32 = 1'b1;
                    h32_imm = if32.out_imm;
                    h32_fmt = if32.out_fmt;
                end
            end else begin
                if (hold32) chk("stall_valid32", 64'(if32.out_valid), 64'd1);
                hold32 = 1'b0;
            end
        end
    end

    initial begin
        vecs[0]  = mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 32'hFFFF_FFFF, 3'd1);
        vecs[1]  = mk(32'hFE113C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 32'hFFFF_FFF8, 3'd2);
        vecs[2]  = mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 32'hFFFF_FFFC, 3'd3);
        vecs[3]  = mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 32'h8000_0000, 3'd4);
        vecs[4]  = mk(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 32'hFFFF_FFF8, 3'd5);
        vecs[5]  = mk(32'h0000007F, 64'h0, 3'd7, 32'h0, 3'd7);
        vecs[6]  = mk(32'h00000033, 64'h0, 3'd0, 32'h0, 3'd0);
        vecs[7]  = mk(32'h0000003B, 64'h0, 3'd0, 32'h0, 3'd7);
        vecs[8]  = mk(32'h0010809B, 64'h1, 3'd1, 32'h0, 3'd7);
        vecs[9]  = mk(32'h4030D093, SRAI_IMM, 3'd1, SRAI_IMM[31:0], 3'd1);
        vecs[10] = mk(32'h0000000F, 64'h0, 3'd0, 32'h0, 3'd0);
        vecs[11] = mk(32'h00000073, 64'h0, 3'd0, 32'h0, 3'd0);
        vecs[12] = mk(32'h80002083, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 32'hFFFF_F800, 3'd1);
        vecs[13] = mk(32'h7FF08067, 64'h7FF, 3'd1, 32'h7FF, 3'd1);
        vecs[14] = mk(32'h12345097, 64'h1234_5000, 3'd4, 32'h1234_5000, 3'd4);
        vecs[15] = mk(32'h00000463, 64'h8, 3'd3, 32'h8, 3'd3);
        vecs[16] = mk(32'h0020006F, 64'h2, 3'd5, 32'h2, 3'd5);

        // Reset state: asynchronous entry, all outputs low.
        #1 reset_n = 1'b0;
        #2;
        chk("rst_in_ready64", 64'(if64.in_ready), 64'd0);
        chk("rst_out_valid64", 64'(if64.out_valid), 64'd0);
        chk("rst_out_imm64", if64.out_imm, 64'd0);
        chk("rst_out_fmt64", 64'(if64.out_fmt), 64'd0);
        chk("rst_out_err64", 64'(if64.out_err), 64'd0);
        chk("rst_err_cnt64", 64'(if64.err_cnt), 64'd0);
        chk("rst_in_ready32", 64'(if32.in_ready), 64'd0);
        chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready64", 64'(if64.in_ready), 64'd1);
        chk("post_rst_in_ready32", 64'(if32.in_ready), 64'd1);

        // Latency: presented this cycle, accepted at the next edge, visible after the one after.
        tb_valid = 1'b1;
        tb_instr = vecs[0].instr;
        q64.push_back(vecs[0]);
        q32.push_back(vecs[0]);
        @(posedge clk);
        #1 tb_valid = 1'b0;
        chk("lat_valid_early", 64'(if64.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_on_time", 64'(if64.out_valid), 64'd1);
        drain();

        // Full-throughput table pass.
        tb_oready = 1'b1;
        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Backpressure: two accepted, third blocked, then one per cycle on release.
        tb_oready = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        tb_valid = 1'b1;
        tb_instr = vecs[3].instr;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(if64.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 tb_oready = 1'b1;
        send(vecs[3]);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drain_rate", 64'(q64.size()), 64'd0);
        drain();

        // Random backpressure table pass.
        rand_rdy = 1'b1;
        foreach (vecs[i]) send(vecs[i]);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 tb_oready = 1'b1;
        drain();

        // Saturating counter from a clean reset: 1,2,3,3,3 checked by the monitor.
        do_reset();
        repeat (5) send(vecs[5]);
        drain();
        chk("sat_err_cnt64", 64'(if64.err_cnt), 64'd3);
        chk("sat_err_cnt32", 64'(if32.err_cnt), 64'd5);

        // Mid-stream reset: in-flight entries vanish immediately and never emerge.
        send(vecs[5]);
        tb_valid = 1'b1;
        tb_instr = vecs[4].instr;
        #2 reset_n = 1'b0;
        q64.delete(); q32.delete();
        nerr64 = 0; nerr32 = 0;
        #1;
        chk("mid_rst_out_valid64", 64'(if64.out_valid), 64'd0);
        chk("mid_rst_err_cnt64", 64'(if64.err_cnt), 64'd0);
        chk("mid_rst_in_ready64", 64'(if64.in_ready), 64'd0);
        chk("mid_rst_out_valid32", 64'(if32.out_valid), 64'd0);
        tb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_output64", 64'(if64.out_valid), 64'd0);
        chk("mid_rst_no_output32", 64'(if32.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
